// File: rtl/ucore_axi_pkg.sv
// ucore_axi_pkg: AXI response/size constants and FSM state encodings shared by ucore AXI targets.
package ucore_axi_pkg;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} w_state_t;
endpackage

// File: rtl/axi_mem_ram.sv
// axi_mem_ram: DEPTH x 32 word array, byte-enabled synchronous write, registered read.
module axi_mem_ram #(
    parameter int DEPTH = 1024,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    we,
    input  logic [IW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [IW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
    // Read register holds its value between reads so the R channel stays stable.
    always_ff @(posedge clk) begin
        if (reset) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: single-beat AXI4 RAM target with independent read and write FSMs.
// Define AXI_MEM_RESPONDER_DECERR_EN to answer out-of-range addresses with DECERR instead of aliasing.
module axi_mem_responder
    import ucore_axi_pkg::*;
#(
    parameter int ADDR_W   = 28,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m_axi_araddr,
    input  logic [2:0]        m_axi_arsize,
    input  logic              m_axi_arvalid,
    output logic              m_axi_arready,
    output logic [DATA_W-1:0] m_axi_rdata,
    output logic [1:0]        m_axi_rresp,
    output logic              m_axi_rlast,
    output logic              m_axi_rvalid,
    input  logic              m_axi_rready,
    input  logic [ADDR_W-1:0] m_axi_awaddr,
    input  logic [2:0]        m_axi_awsize,
    input  logic              m_axi_awvalid,
    output logic              m_axi_awready,
    input  logic [DATA_W-1:0] m_axi_wdata,
    input  logic [3:0]        m_axi_wstrb,
    input  logic              m_axi_wlast,
    input  logic              m_axi_wvalid,
    output logic              m_axi_wready,
    output logic [1:0]        m_axi_bresp,
    output logic              m_axi_bvalid,
    input  logic              m_axi_bready
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = READ_LAT > 1 ? 4'(READ_LAT - 2) : 4'd0;
    r_state_t r_state, r_next;
    w_state_t w_state, w_next;
    logic [3:0] cnt;
    logic [IW-1:0] r_idx, w_idx, ram_raddr;
    logic r_err, w_err, ar_err, aw_err, rd_err, ram_re, ar_hs, aw_hs, w_hs, unused_ok;
    logic [3:0] ram_we;
    logic [31:0] ram_q;
`ifdef AXI_MEM_RESPONDER_DECERR_EN
    assign ar_err = |m_axi_araddr[ADDR_W-1:IW+2];
    assign aw_err = |m_axi_awaddr[ADDR_W-1:IW+2];
`else
    assign ar_err = 1'b0;
    assign aw_err = 1'b0;
`endif
    assign unused_ok = ^{m_axi_arsize, m_axi_awsize, m_axi_wlast, m_axi_araddr, m_axi_awaddr};
    assign ar_hs = m_axi_arvalid && m_axi_arready;
    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;
    // With READ_LAT==1 the array is read straight from araddr on the AR handshake edge.
    assign ram_raddr = r_state == R_IDLE ? m_axi_araddr[IW+1:2] : r_idx;
    assign rd_err    = r_state == R_IDLE ? ar_err : r_err;
    assign ram_we    = w_hs && !w_err ? m_axi_wstrb : 4'b0;
    assign m_axi_rlast = m_axi_rvalid;
    assign m_axi_rdata = m_axi_rresp == AXI_RESP_DECERR ? '0 : ram_q;
    axi_mem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk(clk), .reset(reset), .we(ram_we), .waddr(w_idx), .wdata(m_axi_wdata),
        .re(ram_re), .raddr(ram_raddr), .rdata(ram_q)
    );
    always_comb begin
        r_next = r_state;
        ram_re = 1'b0;
        case (r_state)
            R_IDLE: if (ar_hs) begin
                r_next = READ_LAT == 1 ? R_RESP : R_WAIT;
                ram_re = READ_LAT == 1;
            end
            R_WAIT: if (cnt == '0) begin
                r_next = R_RESP;
                ram_re = 1'b1;
            end
            R_RESP: if (m_axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_ADDR: if (aw_hs) w_next = W_DATA;
            W_DATA: if (w_hs) w_next = W_RESP;
            W_RESP: if (m_axi_bready) w_next = W_ADDR;
            default: w_next = W_ADDR;
        endcase
    end
    // Handshake outputs are registered from the next state, so they read 0 for the cycle after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= R_IDLE;
            cnt           <= '0;
            m_axi_arready <= 1'b0;
            m_axi_rvalid  <= 1'b0;
            m_axi_rresp   <= AXI_RESP_OKAY;
        end else begin
            r_state       <= r_next;
            m_axi_arready <= r_next == R_IDLE;
            m_axi_rvalid  <= r_next == R_RESP;
            if (ar_hs) begin
                r_idx <= m_axi_araddr[IW+1:2];
                r_err <= ar_err;
                cnt   <= CNT_INIT;
            end else if (r_state == R_WAIT) cnt <= cnt - 4'd1;
            if (ram_re) m_axi_rresp <= rd_err ? AXI_RESP_DECERR : AXI_RESP_OKAY;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state       <= W_ADDR;
            m_axi_awready <= 1'b0;
            m_axi_wready  <= 1'b0;
            m_axi_bvalid  <= 1'b0;
            m_axi_bresp   <= AXI_RESP_OKAY;
        end else begin
            w_state       <= w_next;
            m_axi_awready <= w_next == W_ADDR;
            m_axi_wready  <= w_next == W_DATA;
            m_axi_bvalid  <= w_next == W_RESP;
            if (aw_hs) begin
                w_idx <= m_axi_awaddr[IW+1:2];
                w_err <= aw_err;
            end
            if (w_hs) m_axi_bresp <= w_err ? AXI_RESP_DECERR : AXI_RESP_OKAY;
        end
    end
endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- Synthesisable single-beat AXI4 memory responder (slave) for the ucore_main initiator port.
- Replaces the behavioural read handler with a real RAM-backed target for both read and write channels.
- Sits between ucore_main m_axi_* and an on-chip word array; used in simulation and FPGA builds.
- Read and write channels run independent state machines and may be active simultaneously.

Parameters:
- ADDR_W, 28, byte address width of araddr/awaddr
- DATA_W, 32, data width; fixed at 32 (4 strobe lanes)
- DEPTH, 1024, number of DATA_W words in the array; power of two
- READ_LAT, 2, cycles from AR handshake to first rvalid; legal range 1..15

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous active-high reset
- m_axi_araddr  in  ADDR_W  read address (byte)
- m_axi_arsize  in  3  read size; must be 3'b010, otherwise treated as 3'b010
- m_axi_arvalid  in  1  read address valid
- m_axi_arready  out  1  read address ready
- m_axi_rdata  out  DATA_W  read data
- m_axi_rresp  out  2  read response
- m_axi_rlast  out  1  always 1 while rvalid
- m_axi_rvalid  out  1  read data valid
- m_axi_rready  in  1  read data ready
- m_axi_awaddr  in  ADDR_W  write address (byte)
- m_axi_awsize  in  3  write size; treated as 3'b010
- m_axi_awvalid  in  1  write address valid
- m_axi_awready  out  1  write address ready
- m_axi_wdata  in  DATA_W  write data
- m_axi_wstrb  in  4  byte lane strobes
- m_axi_wlast  in  1  ignored (single beat)
- m_axi_wvalid  in  1  write data valid
- m_axi_wready  out  1  write data ready
- m_axi_bresp  out  2  write response
- m_axi_bvalid  out  1  write response valid
- m_axi_bready  in  1  write response ready

Behaviour:
- Reset values (reset high at an edge): arready=0, rvalid=0, rlast=0, rdata=0, rresp=0, awready=0, wready=0, bvalid=0, bresp=0. Both FSMs go to their IDLE state. Array contents are not cleared. Reset mid-transaction abandons it with no response.
- Word index = addr[log2(DEPTH)+1:2]. addr[1:0] is ignored; all accesses are word-aligned.
- Read FSM R_IDLE -> R_WAIT -> R_RESP:
  - R_IDLE: arready=1. Handshake in cycle t latches the address.
  - If READ_LAT==1, go directly to R_RESP. Otherwise go to R_WAIT with a counter that stays READ_LAT-1 cycles.
  - rdata/rresp are registered on the edge entering R_RESP. rvalid=1 and rlast=1 from cycle t+READ_LAT.
  - R_RESP holds rdata, rresp and rvalid stable until rready=1, then returns to R_IDLE. arready is 0 in R_WAIT and R_RESP; next AR is accepted no earlier than the cycle after the R handshake.
- Write FSM W_ADDR -> W_DATA -> W_RESP:
  - W_ADDR: awready=1. AW handshake in cycle t latches the address.
  - W_DATA: wready=1 from t+1. On W handshake in cycle u, bytes with wstrb[i]=1 are written at the edge ending u; wstrb=0 writes nothing and still responds OKAY.
  - W_RESP: bvalid=1 from u+1, held until bready, then back to W_ADDR.
  - wvalid asserted before AW is legal; it simply waits.
- Same-edge read sample and write commit to the same word: read returns the pre-write data.
- rresp/bresp = 2'b00 OKAY unless the optional feature flags an error.

Optional Feature:
- Macro: AXI_MEM_RESPONDER_DECERR_EN.
- Defined: an address with any bit above log2(DEPTH)+1 set is out of range.
  - Read: rresp=2'b11, rdata=32'h0.
  - Write: no array update, bresp=2'b11.
  - Timing is unchanged.
- Undefined: upper bits are ignored (address aliases modulo DEPTH*4) and responses are always OKAY.

Decomposition:
- Shared package ucore_axi_pkg holds: AXI_RESP_OKAY/SLVERR/DECERR constants, AXI_SIZE_4B, R_IDLE/R_WAIT/R_RESP and W_ADDR/W_DATA/W_RESP state encodings.
- One sub-module, axi_mem_ram: DEPTH x 32 array with one byte-enabled synchronous write port and one registered read port.
- The responder instantiates axi_mem_ram and holds both FSMs and the latency counter.

Test Plan:
- Write awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, bready=1, then read araddr=0x10 -> bvalid one cycle after W handshake with bresp=0; rvalid exactly READ_LAT cycles after AR handshake with rdata=0xDEADBEEF, rlast=1, rresp=0.
- Partial strobe write 0x11223344 with wstrb=4'b0101 over 0xDEADBEEF -> read returns 0xDE22BE44.
- Hold rready=0 for 5 cycles after rvalid -> rdata/rvalid stable and arready=0 throughout; next AR is accepted in the cycle after the R handshake.
- Assert wvalid 3 cycles before awvalid -> wready stays 0 until the cycle after the AW handshake; the write completes correctly.
- Concurrent read and write to word 0x20 with AR and W handshakes landing on the same edge (READ_LAT=1) -> read returns the old value; a subsequent read returns the new value.
- With AXI_MEM_RESPONDER_DECERR_EN, read araddr=0x0FFF_FFF0 (DEPTH=1024) -> rresp=2'b11, rdata=0. Without the macro -> data from word index 0x3FC, rresp=0.
- Assert reset while in R_WAIT -> next cycle rvalid=0, arready=0; arready=1 the first cycle after reset deasserts.
